// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller for a 5-stage MIPS pipeline: converts hazard requests into
// per-stage write enables, IF/ID flush and ID/EX bubble, and keeps stall/flush statistics.
module pipeline_stall_controller #(
    parameter int CNT_W        = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_WAIT     = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_hazard,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             stats_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             mem_timeout,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int FL_W   = $clog2(FLUSH_CYCLES + 1);

    localparam logic [WAIT_W-1:0] WAIT_MAX    = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_PRE    = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);
    localparam logic [FL_W-1:0]   FL_RELOAD   = FL_W'(FLUSH_CYCLES - 1);
    localparam logic [FL_W-1:0]   FL_ONE      = FL_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_SAT     = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [FL_W-1:0]   flush_left_q, flush_left_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              stall_inc, flush_inc;

    // Mealy control: outputs depend on current state and this cycle's requests.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        state_d      = state_q;
        flush_left_d = flush_left_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            state_d      = RUN;
        end else if (mem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            stall_inc    = 1'b1;
            if (state_q == RUN) state_d = FREEZE;
        end else if (state_q == FLUSH) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (branch_taken) begin
                flush_inc    = 1'b1;
                flush_left_d = FL_RELOAD;
            end else begin
                flush_left_d = flush_left_q - FL_ONE;
                if (flush_left_q == FL_ONE) state_d = RUN;
            end
        end else begin
            // RUN, or FREEZE released this cycle: both follow the RUN rules
            state_d = RUN;
            if (branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                flush_inc    = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    flush_left_d = FL_RELOAD;
                    state_d      = FLUSH;
                end
            end else if (load_use_hazard) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                stall_inc    = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            flush_left_q <= '0;
            wait_cnt_q   <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;

            if (!mem_busy) wait_cnt_q <= '0;
            else if (wait_cnt_q != WAIT_MAX) wait_cnt_q <= wait_cnt_q + WAIT_ONE;

            // Clear wins over any same-cycle increment or timeout event
            if (stats_clr) begin
                stall_cycles <= '0;
                flush_events <= '0;
                mem_timeout  <= 1'b0;
            end else begin
                if (stall_inc && stall_cycles != CNT_SAT) stall_cycles <= stall_cycles + CNT_ONE;
                if (flush_inc && flush_events != CNT_SAT) flush_events <= flush_events + CNT_ONE;
                if (mem_busy && wait_cnt_q == WAIT_PRE) mem_timeout <= 1'b1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: vector table plus hand-written reset,
// saturation and mid-flush reset sequences.
module tb_pipeline_stall_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_use_hazard, branch_taken, mem_busy, stats_clr;
    logic       pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_bubble;
    logic [3:0] stall_cycles, flush_events;
    logic       mem_timeout;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    pipeline_stall_controller #(
        .CNT_W(4),
        .FLUSH_CYCLES(2),
        .MAX_WAIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_use_hazard(load_use_hazard),
        .branch_taken(branch_taken),
        .mem_busy(mem_busy),
        .stats_clr(stats_clr),
        .pc_write(pc_write),
        .if_id_write(if_id_write),
        .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write),
        .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble),
        .stall_cycles(stall_cycles),
        .flush_events(flush_events),
        .mem_timeout(mem_timeout),
        .state(state)
    );

    always #5 clk = ~clk;

    // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_bubble}
    localparam logic [5:0] O_RUN   = 6'b111100;
    localparam logic [5:0] O_LU    = 6'b001101;
    localparam logic [5:0] O_BR    = 6'b111111;
    localparam logic [5:0] O_FROZE = 6'b000000;

    typedef struct {
        logic       lu, br, mb, clr;
        logic [5:0] out;
        logic [1:0] st;
        logic [3:0] stall, fev;
        logic       tmo;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic lu, br, mb, clr, input logic [5:0] out,
                                input logic [1:0] st, input logic [3:0] stall, fev,
                                input logic tmo);
        vec_t v;
        v.lu = lu; v.br = br; v.mb = mb; v.clr = clr;
        v.out = out; v.st = st; v.stall = stall; v.fev = fev; v.tmo = tmo;
        return v;
    endfunction

    function automatic logic [5:0] outs();
        return {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_bubble};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic lu, br, mb, clr);
        load_use_hazard = lu;
        branch_taken    = br;
        mem_busy        = mb;
        stats_clr       = clr;
    endtask

    initial begin
        drive(0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset outs", 32'(outs()), 32'(O_FROZE));
        check("reset state", 32'(state), 32'd0);
        check("reset stall", 32'(stall_cycles), 32'd0);
        check("reset timeout", 32'(mem_timeout), 32'd0);
        rst = 1'b0;
        #1;
        check("release outs", 32'(outs()), 32'(O_RUN));
        @(posedge clk);
        #1;

        //               lu br mb clr  out      st stall fev tmo
        vq.push_back(mk(0, 0, 0, 0, O_RUN,   0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, O_LU,    0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, O_RUN,   0, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, O_BR,    2, 1, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, O_BR,    0, 1, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, O_RUN,   0, 1, 1, 0));
        vq.push_back(mk(1, 1, 1, 0, O_FROZE, 1, 2, 1, 0));
        vq.push_back(mk(1, 1, 1, 0, O_FROZE, 1, 3, 1, 0));
        vq.push_back(mk(1, 1, 1, 0, O_FROZE, 1, 4, 1, 0));
        vq.push_back(mk(1, 1, 0, 0, O_BR,    2, 4, 2, 0));
        vq.push_back(mk(1, 0, 0, 0, O_BR,    0, 4, 2, 0));
        vq.push_back(mk(0, 0, 0, 0, O_RUN,   0, 4, 2, 0));
        vq.push_back(mk(0, 1, 0, 0, O_BR,    2, 4, 3, 0));
        vq.push_back(mk(0, 0, 1, 0, O_FROZE, 2, 5, 3, 0));
        vq.push_back(mk(0, 0, 0, 0, O_BR,    0, 5, 3, 0));
        vq.push_back(mk(0, 1, 0, 0, O_BR,    2, 5, 4, 0));
        vq.push_back(mk(0, 1, 0, 0, O_BR,    2, 5, 5, 0));
        vq.push_back(mk(0, 0, 0, 0, O_BR,    0, 5, 5, 0));
        vq.push_back(mk(0, 0, 1, 0, O_FROZE, 1, 6, 5, 0));
        vq.push_back(mk(0, 0, 1, 0, O_FROZE, 1, 7, 5, 0));
        vq.push_back(mk(0, 0, 1, 0, O_FROZE, 1, 8, 5, 0));
        vq.push_back(mk(0, 0, 1, 0, O_FROZE, 1, 9, 5, 1));
        vq.push_back(mk(0, 0, 0, 0, O_RUN,   0, 9, 5, 1));
        vq.push_back(mk(1, 0, 0, 1, O_LU,    0, 0, 0, 0));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].lu, vq[i].br, vq[i].mb, vq[i].clr);
            #3;
            check($sformatf("v%0d outs", i), 32'(outs()), 32'(vq[i].out));
            @(posedge clk);
            #1;
            check($sformatf("v%0d state", i), 32'(state), 32'(vq[i].st));
            check($sformatf("v%0d stall", i), 32'(stall_cycles), 32'(vq[i].stall));
            check($sformatf("v%0d flush_ev", i), 32'(flush_events), 32'(vq[i].fev));
            check($sformatf("v%0d timeout", i), 32'(mem_timeout), 32'(vq[i].tmo));
        end

        // Stall counter saturates at 15 over 20 load-use cycles
        drive(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) @(posedge clk);
        #1;
        check("sat stall", 32'(stall_cycles), 32'd15);
        check("sat outs", 32'(outs()), 32'(O_LU));

        // Asynchronous reset in the middle of a flush sequence
        drive(0, 1, 0, 0);
        @(posedge clk);
        #1;
        check("pre-rst state", 32'(state), 32'd2);
        check("pre-rst flush_ev", 32'(flush_events), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid rst outs", 32'(outs()), 32'(O_FROZE));
        check("mid rst state", 32'(state), 32'd0);
        check("mid rst stall", 32'(stall_cycles), 32'd0);
        check("mid rst flush_ev", 32'(flush_events), 32'd0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check("post rst outs", 32'(outs()), 32'(O_RUN));
        @(posedge clk);
        #1;
        check("post rst state", 32'(state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
